// File: rtl/pkt_serializer.sv
// pkt_serializer: pops packets from the packet FIFO and streams them
// byte-wide with sop/eop framing and an optional XOR checksum byte.
//
// Ports:
//   clk, rstp        clock, synchronous active-high reset
//   fifo_emptyp      FIFO empty flag
//   fifo_dout        registered FIFO head, valid the cycle after a pop
//   fifo_readp       pop request (combinational)
//   tx_data/valid    byte stream to the link transmitter
//   tx_ready         sink accepts on tx_valid && tx_ready
//   tx_sop/tx_eop    first / last byte markers
//   pkt_count        packets fully sent, wraps at 16 bits

package pkt_pkg;

    typedef struct packed {
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [3:0][7:0] data;
    } packet_t;

endpackage

module pkt_serializer
    import pkt_pkg::*;
#(
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstp,
    input  logic        fifo_emptyp,
    input  packet_t     fifo_dout,
    output logic        fifo_readp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [15:0] pkt_count
);

    localparam logic [2:0] LAST = CHECKSUM_EN ? 3'd6 : 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    packet_t     hold_q, hold_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;

    logic        accept;
    logic        last_acc;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_csum;

    function automatic logic [7:0] byte_sel(
        input packet_t    p,
        input logic [2:0] i,
        input logic [7:0] c
    );
        logic [7:0] b;
        unique case (i)
            3'd0:    b = p.dst;
            3'd1:    b = p.src;
            3'd2:    b = p.data[0];
            3'd3:    b = p.data[1];
            3'd4:    b = p.data[2];
            3'd5:    b = p.data[3];
            3'd6:    b = c;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept   = (state_q == SEND) && tx_ready;
    assign last_acc = accept && (idx_q == LAST);
    assign nxt_idx  = idx_q + 3'd1;
    // Running checksum including the byte being accepted this cycle
    assign nxt_csum = csum_q ^ data_q;

    assign fifo_readp = !rstp && !fifo_emptyp &&
                        ((state_q == IDLE) || last_acc);

    // Outputs are registered: the next byte is chosen one cycle ahead
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_emptyp) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hold_d  = fifo_dout;
                idx_d   = 3'd0;
                csum_d  = 8'h00;
                data_d  = fifo_dout.dst;
                valid_d = 1'b1;
                sop_d   = 1'b1;
                eop_d   = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                if (last_acc) begin
                    cnt_d   = cnt_q + 16'd1;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    state_d = fifo_emptyp ? IDLE : LOAD;
                end else if (accept) begin
                    idx_d  = nxt_idx;
                    csum_d = nxt_csum;
                    data_d = byte_sel(hold_q, nxt_idx, nxt_csum);
                    sop_d  = 1'b0;
                    eop_d  = (nxt_idx == LAST);
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = 8'h00;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= 3'd0;
            csum_q  <= 8'h00;
            cnt_q   <= 16'h0000;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign tx_sop    = sop_q;
    assign tx_eop    = eop_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_pkt_serializer.sv
// tb_pkt_serializer: scoreboard bench for pkt_serializer, one instance
// with the checksum byte and one without.
`timescale 1ns/1ps

module tb_pkt_serializer;
    import pkt_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        empty [2];
    logic        readp [2];
    logic        txv   [2];
    logic        rdy   [2];
    logic        sop   [2];
    logic        eop   [2];
    logic [7:0]  txd   [2];
    logic [15:0] cnt   [2];
    packet_t     dout  [2];

    packet_t fq [2][$];
    packet_t pq [2][$];
    exp_t    sb [2][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops    [2];
    int pop_cyc [2];
    int sop_cyc [2];
    int eop_cyc [2];
    logic        have_eop [2];
    logic        b2b      [2];
    logic        held_v   [2];
    logic [9:0]  held     [2];
    logic [15:0] ecnt     [2];

    pkt_serializer #(.CHECKSUM_EN(1'b1)) u_dut0 (
        .clk        (clk),
        .rstp       (rst[0]),
        .fifo_emptyp(empty[0]),
        .fifo_dout  (dout[0]),
        .fifo_readp (readp[0]),
        .tx_data    (txd[0]),
        .tx_valid   (txv[0]),
        .tx_ready   (rdy[0]),
        .tx_sop     (sop[0]),
        .tx_eop     (eop[0]),
        .pkt_count  (cnt[0])
    );

    pkt_serializer #(.CHECKSUM_EN(1'b0)) u_dut1 (
        .clk        (clk),
        .rstp       (rst[1]),
        .fifo_emptyp(empty[1]),
        .fifo_dout  (dout[1]),
        .fifo_readp (readp[1]),
        .tx_data    (txd[1]),
        .tx_valid   (txv[1]),
        .tx_ready   (rdy[1]),
        .tx_sop     (sop[1]),
        .tx_eop     (eop[1]),
        .pkt_count  (cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gm
        exp_t e;

        // FIFO model: registered head and empty flag
        always @(posedge clk) begin
            if (readp[g]) begin
                pops[g]++;
                pop_cyc[g] = cyc;
                if (fq[g].size() > 0) dout[g] <= fq[g].pop_front();
            end
            while (pq[g].size() > 0) fq[g].push_back(pq[g].pop_front());
            empty[g] <= (fq[g].size() == 0);
        end

        always @(negedge clk) begin
            chk("pop_while_empty", 32'(readp[g] & empty[g]), 0);
            chk("pkt_count", cnt[g], ecnt[g]);
            if (rst[g]) begin
                chk("readp_in_rst", readp[g], 0);
                ecnt[g]   = 16'h0000;
                held_v[g] = 1'b0;
                while (sb[g].size() > 0 && !sb[g][0].sop) sb[g].delete(0);
            end else begin
                if (held_v[g]) begin
                    chk("stall_valid", txv[g], 1);
                    chk("stall_bus", {txd[g], sop[g], eop[g]}, held[g]);
                end
                if (txv[g] && sop[g] && !held_v[g]) begin
                    sop_cyc[g] = cyc;
                    if (b2b[g] && have_eop[g])
                        chk("b2b_gap", sop_cyc[g] - eop_cyc[g], 2);
                end
                if (!txv[g]) chk("idle_bus", {txd[g], sop[g], eop[g]}, 0);
                if (txv[g] && rdy[g]) begin
                    held_v[g] = 1'b0;
                    if (sb[g].size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb[g].pop_front();
                        chk("tx_byte", txd[g], e.d);
                        chk("tx_sop", sop[g], e.sop);
                        chk("tx_eop", eop[g], e.eop);
                        if (e.eop) begin
                            ecnt[g]     = ecnt[g] + 16'd1;
                            eop_cyc[g]  = cyc;
                            have_eop[g] = 1'b1;
                        end
                    end
                end else begin
                    held_v[g] = txv[g];
                    held[g]   = {txd[g], sop[g], eop[g]};
                end
            end
        end
    end

    task automatic push_pkt(input int g, input logic [7:0] s,
                            input logic [7:0] dd, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d);
        packet_t    p;
        logic [7:0] bl [7];
        int         n;
        p.src = s;
        p.dst = dd;
        p.data[0] = a;
        p.data[1] = b;
        p.data[2] = c;
        p.data[3] = d;
        pq[g].push_back(p);
        bl[0] = dd; bl[1] = s; bl[2] = a; bl[3] = b;
        bl[4] = c;  bl[5] = d; bl[6] = dd ^ s ^ a ^ b ^ c ^ d;
        n = (g == 0) ? 7 : 6;
        for (int i = 0; i < n; i++)
            sb[g].push_back(exp_t'{d: bl[i], sop: (i == 0), eop: (i == n - 1)});
    endtask

    task automatic drain(input int g);
        int n = 0;
        while ((sb[g].size() != 0 || pq[g].size() != 0 ||
                fq[g].size() != 0 || txv[g]) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 300), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_sop();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(txv[0] && sop[0]) && n < 100);
        chk("sop_timeout", 32'(n >= 100), 0);
    endtask

    int p0;
    logic [15:0] c0;

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; rdy[g] = 1'b1; empty[g] = 1'b1; dout[g] = '0;
            pops[g] = 0; pop_cyc[g] = 0; sop_cyc[g] = 0; eop_cyc[g] = 0;
            have_eop[g] = 1'b0; b2b[g] = 1'b0; held_v[g] = 1'b0;
            held[g] = '0; ecnt[g] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", txv[0], 0);
        chk("rst_data", txd[0], 0);
        chk("rst_readp", readp[0], 0);
        chk("rst_count", cnt[0], 0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // single packet
        p0 = pops[0];
        push_pkt(0, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04);
        drain(0);
        chk("single_pops", pops[0] - p0, 1);
        chk("single_cnt", cnt[0], 1);

        // backpressure on byte idx 2
        p0 = pops[0];
        push_pkt(0, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_sop();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("bp_valid", txv[0], 1);
        chk("bp_data", txd[0], 8'h01);
        repeat (3) @(posedge clk);
        #1 rdy[0] = 1'b1;
        drain(0);
        chk("bp_pops", pops[0] - p0, 1);
        chk("bp_cnt", cnt[0], 2);

        // back-to-back, 4 preloaded
        p0 = pops[0];
        c0 = cnt[0];
        have_eop[0] = 1'b0;
        b2b[0] = 1'b1;
        push_pkt(0, 8'hA0, 8'hB0, 8'h11, 8'h22, 8'h33, 8'h44);
        push_pkt(0, 8'hA1, 8'hB1, 8'h55, 8'h66, 8'h77, 8'h88);
        push_pkt(0, 8'hA2, 8'hB2, 8'h99, 8'hAA, 8'hBB, 8'hCC);
        push_pkt(0, 8'hA3, 8'hB3, 8'hDD, 8'hEE, 8'hFF, 8'h00);
        drain(0);
        b2b[0] = 1'b0;
        chk("b2b_pops", pops[0] - p0, 4);
        chk("b2b_cnt", cnt[0] - c0, 4);

        // empty for 20 cycles, then a write
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("empty_readp", readp[0], 0);
            chk("empty_valid", txv[0], 0);
        end
        @(posedge clk); #1;
        push_pkt(0, 8'h5A, 8'hC3, 8'hF0, 8'h0F, 8'h81, 8'h7E);
        drain(0);
        chk("empty_latency", sop_cyc[0] - pop_cyc[0], 2);

        // reset after byte idx 3 accepted
        push_pkt(0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        push_pkt(0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60);
        wait_sop();
        repeat (4) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", txv[0], 0);
        chk("mid_rst_bus", {txd[0], sop[0], eop[0]}, 0);
        chk("mid_rst_cnt", cnt[0], 0);
        drain(0);
        chk("post_rst_cnt", cnt[0], 1);

        // no checksum, counter wrap
        @(posedge clk); #1;
        force u_dut1.cnt_q = 16'hFFFF;
        ecnt[1] = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut1.cnt_q;
        @(posedge clk); #1;
        chk("force_cnt", cnt[1], 16'hFFFF);
        push_pkt(1, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04);
        drain(1);
        chk("wrap_cnt", cnt[1], 16'h0000);
        chk("wrap_pops", pops[1], 1);

        chk("sb_left0", sb[0].size(), 0);
        chk("sb_left1", sb[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
